chip_7458_tester: RTL
=====================

Name: chip_7458_tester

Overview:
Self-checking sequencer for the 7458 AND-OR datapath. On a start pulse it walks all 1024 input combinations through an external chip_7458 instance and waits a programmable settle time per vector. It compares p1y/p2y against an internal golden model and counts mismatches. It sits beside the chip_7458 instance in the lab top level and reports done/pass to board LEDs.

Parameters:
SETTLE_CYCLES, 1, cycles between driving a vector and sampling DUT outputs; legal range >= 1
ERR_W, 11, width of the mismatch counter; the counter saturates at 2^ERR_W-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle run request; accepted only in IDLE or DONE
abort  input  1  stop the run and return to IDLE; only effective in SETTLE or CHECK
dut_in  output  10  vector driven to DUT; bits [5:0]=p1a..p1f, bits [9:6]=p2a..p2d
dut_p1y  input  1  DUT p1y
dut_p2y  input  1  DUT p2y
busy  output  1  high in SETTLE or CHECK
done  output  1  high in DONE
pass  output  1  high in DONE when err_count==0
err_count  output  ERR_W  mismatch count for the current or last run

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset is high: state=IDLE, dut_in=0, settle counter=0, err_count=0, busy=0, done=0, pass=0.
- Golden model:
  - exp_p1y = (v0&v1&v2)|(v3&v4&v5)
  - exp_p2y = (v6&v7)|(v8&v9)
  - v = dut_in. The model is combinational from the dut_in register.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE: on start, dut_in<=0, cnt<=0, err_count<=0, go to SETTLE.
- SETTLE:
  - If cnt==SETTLE_CYCLES-1, go to CHECK; otherwise cnt<=cnt+1.
  - dut_in is held stable.
- CHECK:
  - Sample dut_p1y/dut_p2y.
  - If either output differs from the golden model, err_count<=err_count+1, saturating at all-ones. Exactly one increment per vector, even if both outputs differ.
  - If dut_in==10'h3FF, go to DONE. Otherwise dut_in<=dut_in+1, cnt<=0, go to SETTLE.
- DONE:
  - done=1; pass=(err_count==0); dut_in holds 10'h3FF; err_count holds.
  - start restarts exactly as from IDLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles. busy is high for 1024*(SETTLE_CYCLES+1) cycles (2048 at default).
  - done rises on the cycle after the final CHECK.
- Simultaneous and boundary events:
  - abort in SETTLE or CHECK: go to IDLE next cycle. dut_in<=0, err_count holds, done stays 0.
  - abort has priority over the CHECK update; the vector being checked is not counted.
  - start and abort together in IDLE/DONE: start wins, abort is ignored.
  - start while busy is ignored.
- No wrap-around: dut_in never increments past 10'h3FF.
- Reset mid-run: immediate return to reset values; no partial result is retained.

Optional Feature:
Macro CHIP7458_TESTER_FIRST_FAIL_EN.
- Defined:
  - Adds outputs ff_valid (1), ff_vec (10) and ff_obs (2, {p2y,p1y} observed).
  - On the first mismatching CHECK of a run, these capture dut_in and the observed outputs, and ff_valid is set. Later mismatches do not overwrite them.
  - start clears all three; reset forces all three to 0.
- Undefined: these ports and registers do not exist; the rest of the behaviour is identical.

Test Plan:
1. Correct chip_7458 connected, SETTLE_CYCLES=1, start pulse -> busy high exactly 2048 cycles, then done=1, pass=1, err_count=0, dut_in=10'h3FF.
2. Model p2y stuck-at-0 -> err_count=448 (7/16 of 1024), pass=0. With FIRST_FAIL_EN: ff_vec=10'h0C0 (192), ff_obs=2'b00, ff_valid=1.
3. Model p1y inverted with ERR_W=4 -> err_count saturates at 15 and stays 15; pass=0. With ERR_W=11 -> err_count=1024.
4. abort while dut_in=100 in CHECK -> next cycle IDLE, busy=0, done=0, dut_in=0, err_count unchanged. A following start runs the clean full 2048-cycle sequence of test 1.
5. reset asserted mid-SETTLE at dut_in=500 -> outputs zero in the same cycle (asynchronously), before the next clk edge. State stays IDLE after deassert until start.
6. SETTLE_CYCLES=3: start pulsed again while busy is ignored; run takes 4096 cycles. start in DONE clears done and err_count on the next cycle, and busy rises.

Source files
------------

// File: rtl/chip_7458_tester.sv
// Sequencer that sweeps all 1024 vectors through an external 7458 and counts mismatches against a golden model.
// Optional first-failure capture ports are enabled by defining CHIP7458_TESTER_FIRST_FAIL_EN.
module chip_7458_tester #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [9:0]       dut_in,
  input  logic             dut_p1y,
  input  logic             dut_p2y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef CHIP7458_TESTER_FIRST_FAIL_EN
  ,
  output logic             ff_valid,
  output logic [9:0]       ff_vec,
  output logic [1:0]       ff_obs
`endif
);

  localparam int unsigned    CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [9:0]     VEC_LAST = 10'h3FF;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [9:0]       dut_in_n;
  logic [ERR_W-1:0] err_n;
  logic             busy_n, done_n, pass_n;
  logic             exp_p1y_c, exp_p2y_c, mismatch_c;

  // Golden 7458 model, driven from the registered vector
  assign exp_p1y_c  = (dut_in[0] & dut_in[1] & dut_in[2]) | (dut_in[3] & dut_in[4] & dut_in[5]);
  assign exp_p2y_c  = (dut_in[6] & dut_in[7]) | (dut_in[8] & dut_in[9]);
  assign mismatch_c = (dut_p1y != exp_p1y_c) | (dut_p2y != exp_p2y_c);

`ifdef CHIP7458_TESTER_FIRST_FAIL_EN
  logic       ff_valid_n;
  logic [9:0] ff_vec_n;
  logic [1:0] ff_obs_n;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dut_in    <= '0;
      err_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
`ifdef CHIP7458_TESTER_FIRST_FAIL_EN
      ff_valid  <= 1'b0;
      ff_vec    <= '0;
      ff_obs    <= '0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dut_in    <= dut_in_n;
      err_count <= err_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
`ifdef CHIP7458_TESTER_FIRST_FAIL_EN
      ff_valid  <= ff_valid_n;
      ff_vec    <= ff_vec_n;
      ff_obs    <= ff_obs_n;
`endif
    end
  end

  // Next-state and registered-output logic; abort outranks the CHECK update
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dut_in_n = dut_in;
    err_n    = err_count;
`ifdef CHIP7458_TESTER_FIRST_FAIL_EN
    ff_valid_n = ff_valid;
    ff_vec_n   = ff_vec;
    ff_obs_n   = ff_obs;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n  = SETTLE;
          dut_in_n = '0;
          cnt_n    = '0;
          err_n    = '0;
`ifdef CHIP7458_TESTER_FIRST_FAIL_EN
          ff_valid_n = 1'b0;
          ff_vec_n   = '0;
          ff_obs_n   = '0;
`endif
        end
      end
      SETTLE: begin
        if (abort) begin
          state_n  = IDLE;
          dut_in_n = '0;
          cnt_n    = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = CHECK;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      CHECK: begin
        if (abort) begin
          state_n  = IDLE;
          dut_in_n = '0;
          cnt_n    = '0;
        end else begin
          if (mismatch_c && (err_count != ERR_MAX)) begin
            err_n = err_count + ERR_W'(1);
          end
`ifdef CHIP7458_TESTER_FIRST_FAIL_EN
          if (mismatch_c && !ff_valid) begin
            ff_valid_n = 1'b1;
            ff_vec_n   = dut_in;
            ff_obs_n   = {dut_p2y, dut_p1y};
          end
`endif
          if (dut_in == VEC_LAST) begin
            state_n = DONE;
          end else begin
            state_n  = SETTLE;
            dut_in_n = dut_in + 10'd1;
            cnt_n    = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == SETTLE) || (state_n == CHECK);
    done_n = (state_n == DONE);
    pass_n = (state_n == DONE) && (err_n == '0);
  end

endmodule
